// File: rtl/bus_mem_responder.sv
// Byte-wide memory responder for the x86cpu bus: fixed-latency read pipeline,
// write-protected ROM window at the top, and a power-up clear of the RAM window.
module bus_mem_responder #(
    parameter int            AW       = 16,
    parameter int            RD_LAT   = 2,
    parameter logic [AW-1:0] ROM_BASE = 16'hF000,
    parameter bit            CLEAR_EN = 1'b1,
    parameter logic [7:0]    FILL     = 8'h00
) (
    input  logic        clock,
    input  logic        locked,
    input  logic [19:0] address,
    input  logic [7:0]  o_data,
    input  logic        rd,
    input  logic        wr,
    output logic [7:0]  i_data,
    output logic        ready,
    output logic        wp_err
);

    localparam logic [0:0]    ST_CLEAR = 1'b0;
    localparam logic [0:0]    ST_RUN   = 1'b1;
    localparam logic [AW-1:0] CLR_LAST = ROM_BASE - 1'b1;

    logic [0:0]             state;
    logic [AW-1:0]          clr_cnt;
    logic [AW-1:0]          index;
    logic                   running;
    logic                   cpu_wr_ok;
    logic [7:0]             load;
    logic [RD_LAT-1:0][7:0] pipe;
    logic [RD_LAT-1:0][7:0] pipe_next;
    logic [7:0]             mem [2**AW];

    // Upper address bits alias onto the same byte.
    assign index     = address[AW-1:0];
    assign running   = (state == ST_RUN);
    assign cpu_wr_ok = running && wr && (index < ROM_BASE);

    if (AW < 20) begin : g_unused
        logic unused_upper;
        assign unused_upper = ^address[19:AW];
    end

    // ready tracks the state we are about to be in, so it rises on the same
    // edge that writes the last RAM byte.
    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            state   <= CLEAR_EN ? ST_CLEAR : ST_RUN;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == CLR_LAST) begin
                state <= ST_RUN;
                ready <= 1'b1;
            end
        end else begin
            ready <= 1'b1;
        end
    end

    // NOTE: the byte array is deliberately left out of reset; a reset on a
    // memory this size blocks RAM inference, and the clear FSM defines its contents.
    always_ff @(posedge clock) begin
        if (locked && state == ST_CLEAR) begin
            mem[clr_cnt] <= FILL;
        end else if (locked && cpu_wr_ok) begin
            mem[index] <= o_data;
        end
    end

    // Stage 0 loads on rd (0xFF while clearing) and otherwise holds; the rest shift.
    assign load = rd ? (running ? mem[index] : 8'hFF) : pipe[0];

    if (RD_LAT == 1) begin : g_lat1
        assign pipe_next = load;
    end else begin : g_latn
        assign pipe_next = {pipe[RD_LAT-2:0], load};
    end

    always_ff @(posedge clock or negedge locked) begin
        if (!locked) begin
            pipe   <= '0;
            wp_err <= 1'b0;
        end else begin
            pipe   <= pipe_next;
            wp_err <= running && wr && (index >= ROM_BASE);
        end
    end

    assign i_data = pipe[RD_LAT-1];

endmodule
